// File: rtl/adaptfilt_pkg.sv
// Shared defaults and error-domain bounds for the adaptive-filter chain (FIR, LMS, error monitor).
package adaptfilt_pkg;
  localparam int W1_DEF    = 12;
  localparam int W2_DEF    = 32;
  localparam int SHIFT_DEF = 21;
  localparam int LOG2N_DEF = 4;

  localparam logic signed [W1_DEF-1:0] ERR_MAX = {1'b0, {(W1_DEF-1){1'b1}}};
  localparam logic signed [W1_DEF-1:0] ERR_MIN = {1'b1, {(W1_DEF-1){1'b0}}};
  localparam logic [15:0]              SAT_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/fir_err_monitor_if.sv
// Sample/error bus between the FIR integrator and the error monitor.
interface fir_err_monitor_if
  import adaptfilt_pkg::*;
#(
  parameter int W1 = W1_DEF,
  parameter int W2 = W2_DEF
);
  logic                 in_valid;
  logic signed [W2-1:0] y_in;
  logic signed [W1-1:0] d_in;
  logic                 clr;
  logic signed [W1-1:0] e_out;
  logic                 e_valid;
  logic [2*W1-1:0]      pwr_out;
  logic                 pwr_valid;
  logic [15:0]          sat_cnt;

  modport master (output in_valid, y_in, d_in, clr,
                  input  e_out, e_valid, pwr_out, pwr_valid, sat_cnt);
  modport slave  (input  in_valid, y_in, d_in, clr,
                  output e_out, e_valid, pwr_out, pwr_valid, sat_cnt);
endinterface

// File: rtl/fir_err_monitor_acc.sv
// err_power_acc: squares each valid error and emits the mean over 2^LOG2N-sample windows.
module err_power_acc
  import adaptfilt_pkg::*;
#(
  parameter int W1    = W1_DEF,
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [W1-1:0] e,
  input  logic                 ev,
  input  logic                 clr,
  output logic [2*W1-1:0]      pwr_out,
  output logic                 pwr_valid
);
  localparam int PW = 2*W1;
  localparam int AW = 2*W1 + LOG2N;

  logic [PW-1:0]    sq;
  logic [AW-1:0]    acc, sum;
  logic [LOG2N-1:0] cnt;

  assign sq  = e * e;
  assign sum = acc + AW'(sq);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      cnt       <= '0;
      pwr_out   <= '0;
      pwr_valid <= 1'b0;
    end else begin
      pwr_valid <= 1'b0;
      // clr wins over the sample arriving in the same cycle; that sample is dropped
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (ev) begin
        if (&cnt) begin
          pwr_out   <= PW'(sum >> LOG2N);
          pwr_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + LOG2N'(1);
        end
      end
    end
  end
endmodule

// File: rtl/fir_err_monitor.sv
// Error monitor: rescale FIR output, subtract from d_in, optionally clip, and track error power.
// ERR_SAT_EN selects saturating error with sat_cnt; otherwise the error wraps and sat_cnt is 0.
module fir_err_monitor
  import adaptfilt_pkg::*;
#(
  parameter int W1    = W1_DEF,
  parameter int W2    = W2_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int LOG2N = LOG2N_DEF
) (
  input logic              clk,
  input logic              reset,
  fir_err_monitor_if.slave bus
);
  localparam int STAGES = 2;

  logic [STAGES:1]      vld_pipe;
  logic signed [W2-1:0] ys;
  logic [W1:0]          diff_c, diff_q;
  logic [W1-1:0]        e_q;
  logic [15:0]          sat_q;
  logic [2*W1-1:0]      pwr;
  logic                 pv;

  assign ys     = bus.y_in >>> SHIFT;
  // one extra bit holds the full difference of two W1-bit signed values
  assign diff_c = {bus.d_in[W1-1], bus.d_in} - ys[W1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      diff_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
      if (bus.in_valid) diff_q <= diff_c;
    end
  end

`ifdef ERR_SAT_EN
  logic ovf;
  assign ovf = diff_q[W1] ^ diff_q[W1-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q   <= '0;
      sat_q <= '0;
    end else begin
      e_q <= ovf ? (diff_q[W1] ? W1'(ERR_MIN) : W1'(ERR_MAX)) : diff_q[W1-1:0];
      if (bus.clr)
        sat_q <= '0;
      else if (vld_pipe[1] && ovf && sat_q != SAT_CNT_MAX)
        sat_q <= sat_q + 16'd1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ys[W2-1:W1+1]};
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) e_q <= '0;
    else        e_q <= diff_q[W1-1:0];
  end
  assign sat_q = '0;

  logic unused_ok;
  assign unused_ok = ^{ys[W2-1:W1+1], diff_q[W1]};
`endif

  err_power_acc #(.W1(W1), .LOG2N(LOG2N)) u_pwr (
    .clk       (clk),
    .reset     (reset),
    .e         (e_q),
    .ev        (vld_pipe[STAGES]),
    .clr       (bus.clr),
    .pwr_out   (pwr),
    .pwr_valid (pv)
  );

  assign bus.e_out     = e_q;
  assign bus.e_valid   = vld_pipe[STAGES];
  assign bus.pwr_out   = pwr;
  assign bus.pwr_valid = pv;
  assign bus.sat_cnt   = sat_q;
endmodule

// File: tb/tb_fir_err_monitor.sv
// Scoreboard bench for fir_err_monitor: directed vectors, expected responses queued with due cycle.
module tb_fir_err_monitor;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_err_monitor_if bus ();

  fir_err_monitor dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic signed [11:0] e; logic [15:0] s; int c; } eexp_t;
  typedef struct { logic [23:0] p; int c; } pexp_t;
  eexp_t eq[$];
  pexp_t pq[$];
  logic [15:0] sat_exp = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // monitor: compare whatever the DUT presents against the head of each queue
  always @(negedge clk) begin
    while (eq.size() > 0 && eq[0].c < cyc) begin
      checks++; errors++;
      $display("FAIL e_missing actual=none required_cycle=%0d", eq[0].c);
      void'(eq.pop_front());
    end
    while (pq.size() > 0 && pq[0].c < cyc) begin
      checks++; errors++;
      $display("FAIL pwr_missing actual=none required_cycle=%0d", pq[0].c);
      void'(pq.pop_front());
    end
    if (reset && bus.e_valid) begin
      if (eq.size() == 0) begin
        checks++; errors++;
        $display("FAIL e_unexpected actual=%0d required=none", bus.e_out);
      end else begin
        eexp_t x;
        x = eq.pop_front();
        chk("e_out", 32'(bus.e_out), 32'(x.e));
        chk("sat_cnt", 32'(bus.sat_cnt), 32'(x.s));
        chk("e_cycle", 32'(cyc), 32'(x.c));
      end
    end
    if (reset && bus.pwr_valid) begin
      if (pq.size() == 0) begin
        checks++; errors++;
        $display("FAIL pwr_unexpected actual=%0d required=none", bus.pwr_out);
      end else begin
        pexp_t x;
        x = pq.pop_front();
        chk("pwr_out", 32'(bus.pwr_out), 32'(x.p));
        chk("pwr_cycle", 32'(cyc), 32'(x.c));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // drive one sample; expected error queued for 2 cycles on, window mean for 3 on
  task automatic send(input int y, input int d, input int e, input bit last, input int p);
    eexp_t x;
    pexp_t q;
    x.e = 12'(e); x.s = sat_exp; x.c = cyc + 2;
    eq.push_back(x);
    if (last) begin q.p = 24'(p); q.c = cyc + 3; pq.push_back(q); end
    bus.in_valid = 1'b1; bus.y_in = y; bus.d_in = 12'(d);
    tick(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1; tick(1); bus.clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.y_in = '0; bus.d_in = '0; bus.clr = 1'b0;
    #12;
    chk("rst_e_out", 32'(bus.e_out), 0);
    chk("rst_e_valid", 32'(bus.e_valid), 0);
    chk("rst_pwr_out", 32'(bus.pwr_out), 0);
    chk("rst_pwr_valid", 32'(bus.pwr_valid), 0);
    chk("rst_sat_cnt", 32'(bus.sat_cnt), 0);
    reset = 1'b1;
    tick(2);

    // basic error
    send(100 << 21, 300, 200, 0, 0);
    tick(3);

    // saturation cases
`ifdef ERR_SAT_EN
    sat_exp = 16'd1; send(-(1000 << 21), 2047, 2047, 0, 0);
    sat_exp = 16'd2; send(1000 << 21, -2048, -2048, 0, 0);
`else
    send(-(1000 << 21), 2047, -1049, 0, 0);
    send(1000 << 21, -2048, 1048, 0, 0);
`endif
    tick(4);
    pulse_clr();
    sat_exp = 16'd0;
    tick(1);

    // full window e=-4, back to back
    for (int i = 0; i < 16; i++) send(4 << 21, 0, -4, i == 15, 16);
    tick(4);

    // same window with gaps
    for (int i = 0; i < 16; i++) begin
      send(4 << 21, 0, -4, i == 15, 16);
      tick(i % 3);
    end
    tick(4);

    // clr collides with the 16th sample's e_valid: no power update
    for (int i = 0; i < 16; i++) send(-(1 << 21), 0, 1, 0, 0);
    tick(1);
    pulse_clr();
    tick(3);
    for (int i = 0; i < 16; i++) send(-(2 << 21), 0, 2, i == 15, 4);
    tick(4);

    // reset part-way through a window
    for (int i = 0; i < 10; i++) send(5 << 21, 10, 5, 0, 0);
    tick(3);
    reset = 1'b0;
    #1;
    chk("mid_rst_e_out", 32'(bus.e_out), 0);
    chk("mid_rst_e_valid", 32'(bus.e_valid), 0);
    chk("mid_rst_pwr_out", 32'(bus.pwr_out), 0);
    chk("mid_rst_pwr_valid", 32'(bus.pwr_valid), 0);
    chk("mid_rst_sat_cnt", 32'(bus.sat_cnt), 0);
    tick(2);
    reset = 1'b1;
    sat_exp = 16'd0;
    tick(1);
    for (int i = 0; i < 16; i++) send(7 << 21, 10, 3, i == 15, 9);
    tick(6);

    chk("e_queue_drained", 32'(eq.size()), 0);
    chk("pwr_queue_drained", 32'(pq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
